// File: rtl/seg7_scan_drv.sv
// seg7_scan_drv: scans an 8-digit common-anode 7-segment display.
// The 32-bit word is shown as 8 hex digits. Each digit has its own decimal
// point and blink enable. Inputs are snapshotted once per frame, so a change
// partway through a frame does not tear the displayed value.
module seg7_scan_drv #(
    parameter int DIV_W   = 17,
    parameter int BLINK_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] disp_num,
    input  logic [7:0]  point,
    input  logic [7:0]  les,
    output logic [7:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic        frame_done
);

    localparam logic [DIV_W-1:0]   PRESC_ONE = DIV_W'(1);
    localparam logic [BLINK_W-1:0] FRAME_ONE = BLINK_W'(1);

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        unique case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    logic [DIV_W-1:0]   presc_q, presc_d;
    logic [2:0]         dig_q, dig_d;
    logic [BLINK_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [31:0]        snap_num_q, snap_num_d;
    logic [7:0]         snap_pt_q, snap_pt_d;
    logic [7:0]         snap_les_q, snap_les_d;
    logic [7:0]         an_q, an_d;
    logic [7:0]         seg_q, seg_d;
    logic               frame_done_q, frame_done_d;

    logic               tick;
    logic               boundary;
    logic [3:0]         nib;
    logic               blank;

    // The scan sequencer plus the output decode for the digit selected now.
    always_comb begin
        // NOTE: every output gets a default first, so no path through this block can infer a latch.
        presc_d      = presc_q + PRESC_ONE;
        dig_d        = dig_q;
        frame_cnt_d  = frame_cnt_q;
        snap_num_d   = snap_num_q;
        snap_pt_d    = snap_pt_q;
        snap_les_d   = snap_les_q;
        frame_done_d = 1'b0;

        tick     = &presc_q;
        boundary = tick && (dig_q == 3'd7);

        if (tick) begin
            dig_d = dig_q + 3'd1;
        end
        // The last digit's slot is ending, so capture the inputs for the next frame.
        if (boundary) begin
            snap_num_d   = disp_num;
            snap_pt_d    = point;
            snap_les_d   = les;
            frame_cnt_d  = frame_cnt_q + FRAME_ONE;
            frame_done_d = 1'b1;
        end

        // The decode uses only the snapshots, never the live inputs.
        nib   = snap_num_q[{dig_q, 2'b00} +: 4];
        blank = snap_les_q[dig_q] & frame_cnt_q[BLINK_W-1];
        an_d  = blank ? 8'hFF : ~(8'h01 << dig_q);
        seg_d = blank ? 8'hFF : {~snap_pt_q[dig_q], hex7(nib)};
    end

    // State and registered outputs. Reset blanks the display at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            dig_q        <= '0;
            frame_cnt_q  <= '0;
            snap_num_q   <= '0;
            snap_pt_q    <= '0;
            snap_les_q   <= '0;
            an_q         <= 8'hFF;
            seg_q        <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample values from before the edge.
            presc_q      <= presc_d;
            dig_q        <= dig_d;
            frame_cnt_q  <= frame_cnt_d;
            snap_num_q   <= snap_num_d;
            snap_pt_q    <= snap_pt_d;
            snap_les_q   <= snap_les_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign AN         = an_q;
    assign SEGMENT    = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Directed bench for seg7_scan_drv with DIV_W=2 and BLINK_W=2, so a frame is 32 clocks.
module tb_seg7_scan_drv;

    localparam int DIV_W   = 2;
    localparam int BLINK_W = 2;

    logic        clk;
    logic        rst;
    logic [31:0] disp_num;
    logic [7:0]  point;
    logic [7:0]  les;
    logic [7:0]  AN;
    logic [7:0]  SEGMENT;
    logic        frame_done;

    int total = 0;
    int bad   = 0;
    int fr    = 0;

    typedef struct {
        logic [31:0]     num;
        logic [7:0]      pt;
        logic [7:0]      les;
        logic [7:0][7:0] seg;   // expected SEGMENT per digit, index = digit
        string           name;
    } vec_t;

    vec_t vecs[4];

    localparam logic [7:0][7:0] ALL_C0 = {8{8'hC0}};
    localparam logic [7:0][7:0] ALL_F9 = {8{8'hF9}};
    localparam logic [7:0][7:0] ALL_A4 = {8{8'hA4}};
    localparam logic [7:0][7:0] ALL_B0 = {8{8'hB0}};

    seg7_scan_drv #(
        .DIV_W   (DIV_W),
        .BLINK_W (BLINK_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .disp_num   (disp_num),
        .point      (point),
        .les        (les),
        .AN         (AN),
        .SEGMENT    (SEGMENT),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Walk one 32-cycle frame and compare AN, SEGMENT and frame_done every cycle.
    // blank marks the digits that should be dark. disp_num is changed after sample chg_at.
    task automatic run_frame(input logic [7:0][7:0] exp_seg, input logic [7:0] blank,
                             input int chg_at, input logic [31:0] chg_val, input string name);
        for (int i = 0; i < 32; i++) begin
            int         d;
            logic [7:0] ea;
            logic [7:0] es;
            @(posedge clk);
            @(negedge clk);
            d = i / 4;
            if (blank[d]) begin
                ea = 8'hFF;
                es = 8'hFF;
            end else begin
                ea = ~(8'h01 << d);
                es = exp_seg[d];
            end
            check($sformatf("%s f%0d c%0d AN", name, fr, i), {24'd0, AN}, {24'd0, ea});
            check($sformatf("%s f%0d c%0d SEG", name, fr, i), {24'd0, SEGMENT}, {24'd0, es});
            check($sformatf("%s f%0d c%0d frame_done", name, fr, i), {31'd0, frame_done},
                  {31'd0, (i == 31)});
            if (i == chg_at) disp_num = chg_val;
        end
        fr++;
    endtask

    initial begin
        vecs[0] = '{num: 32'h76543210, pt: 8'h00, les: 8'h00,
                    seg: {8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0}, name: "hex0_7"};
        vecs[1] = '{num: 32'hFEDCBA98, pt: 8'h00, les: 8'h00,
                    seg: {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80}, name: "hex8_F"};
        vecs[2] = '{num: 32'h00000000, pt: 8'hAA, les: 8'h00,
                    seg: {8'h40, 8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0}, name: "points"};
        vecs[3] = '{num: 32'h11111111, pt: 8'h00, les: 8'h00,
                    seg: ALL_F9, name: "ones"};

        rst      = 1'b1;
        disp_num = '0;
        point    = '0;
        les      = '0;

        // Reset held for 3 cycles: the display is dark and there is no frame pulse.
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst AN", {24'd0, AN}, 32'hFF);
            check("rst SEG", {24'd0, SEGMENT}, 32'hFF);
            check("rst frame_done", {31'd0, frame_done}, 32'd0);
        end

        // Release reset. The first frame shows zeros while record 0 is captured at its end.
        rst      = 1'b0;
        disp_num = vecs[0].num;
        point    = vecs[0].pt;
        les      = vecs[0].les;
        run_frame(ALL_C0, 8'h00, -1, 32'h0, "reset_frame");
        run_frame(vecs[0].seg, 8'h00, -1, 32'h0, vecs[0].name);

        // Table: apply a record. One frame still shows the old snapshot, then the new one appears.
        for (int r = 1; r < 4; r++) begin
            disp_num = vecs[r].num;
            point    = vecs[r].pt;
            les      = vecs[r].les;
            run_frame(vecs[r-1].seg, 8'h00, -1, 32'h0, {vecs[r].name, "_prev"});
            run_frame(vecs[r].seg, 8'h00, -1, 32'h0, vecs[r].name);
        end

        // Change mid-frame: the frame still shows 1s, and 2s appear only in the next frame.
        run_frame(ALL_F9, 8'h00, 10, 32'h22222222, "snap_hold");
        // Change just before the boundary edge: the new value is captured at that edge.
        run_frame(ALL_A4, 8'h00, 30, 32'h33333333, "snap_new");
        run_frame(ALL_B0, 8'h00, -1, 32'h0, "edge_capture");

        // Digit 0 has its point lit. Digit 7 blinks on frame_cnt[1] with a 4-frame period.
        disp_num = 32'h0;
        point    = 8'h01;
        les      = 8'h80;
        run_frame(ALL_B0, 8'h00, -1, 32'h0, "blink_prev");
        for (int k = 0; k < 4; k++) begin
            logic [7:0] bl;
            bl = ((fr % 4) >= 2) ? 8'h80 : 8'h00;
            run_frame({{7{8'hC0}}, 8'h40}, bl, -1, 32'h0, "blink");
        end

        // Async reset while digit 5 is lit: the display goes dark without a clock edge.
        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_rst digit5 AN", {24'd0, AN}, 32'hDF);
        #2;
        rst      = 1'b1;
        disp_num = 32'h12345678;
        point    = 8'h00;
        les      = 8'h00;
        #1;
        check("async_rst AN", {24'd0, AN}, 32'hFF);
        check("async_rst SEG", {24'd0, SEGMENT}, 32'hFF);
        check("async_rst frame_done", {31'd0, frame_done}, 32'd0);
        check("async_rst dig", {29'd0, dut.dig_q}, 32'd0);
        check("async_rst frame_cnt", {30'd0, dut.frame_cnt_q}, 32'd0);
        @(posedge clk);
        #1;
        check("held_rst AN", {24'd0, AN}, 32'hFF);
        @(negedge clk);
        #2;
        rst = 1'b0;
        fr  = 0;
        run_frame(ALL_C0, 8'h00, -1, 32'h0, "post_rst_zero");
        run_frame({8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80}, 8'h00, -1, 32'h0,
                  "post_rst_new");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
